// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/ready handshake to data memory, byte-lane
// steering for stores, sign/zero extension for loads, misalign and timeout errors.
module load_store_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic              memEn_i,
  input  logic              memWr_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic signed [31:0] loadResult_o,
  output logic [4:0]        loadrd_o,
  output logic              loadValid_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [7:0]        wait_q;
  logic              err_q;
  logic [31:0]       result_q;
  logic [4:0]        loadrd_q;

  logic        f3_ok, accept, misaligned, start, bad_align, timeout;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_c;

  // Store encodings with funct3[2] set are undefined, so they are ignored like loads 011/11x.
  always_comb begin
    if (memWr_i) f3_ok = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);
    else         f3_ok = (funct3_i != 3'b011) && (funct3_i[2:1] != 2'b11);
  end

  assign accept     = (state == IDLE) && valid_i && memEn_i && f3_ok;
  assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  assign start      = accept && !misaligned;
  assign bad_align  = accept && misaligned;
  assign timeout    = (state == ACCESS) && !dmem_ready_i && (wait_q == WAIT_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    dmem_req_o  = 1'b0;
    busy_o      = 1'b0;
    loadValid_o = 1'b0;
    case (state)
      IDLE: begin
        busy_o = start;
        if (start) state_nxt = ACCESS;
      end
      ACCESS: begin
        dmem_req_o = 1'b1;
        busy_o     = 1'b1;
        if (dmem_ready_i)  state_nxt = we_q ? IDLE : DONE;
        else if (timeout)  state_nxt = IDLE;
      end
      DONE: begin
        busy_o      = 1'b1;
        loadValid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign off = addr_q[1:0];

  always_comb begin
    be_c = 4'b1111;
    wd_c = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be_c = 4'b0001 << off;
        wd_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c = 4'b0011 << {off[1], 1'b0};
        wd_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wdata_q;
      end
    endcase
  end

  assign dmem_we_o    = dmem_req_o && we_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? be_c : '0;
  assign dmem_wdata_o = (dmem_req_o && we_q) ? wd_c : '0;

  assign byte_sel = dmem_rdata_i[{off, 3'b000} +: 8];
  assign half_sel = dmem_rdata_i[{off[1], 4'b0000} +: 16];

  always_comb begin
    ext_c = dmem_rdata_i;
    case (f3_q)
      3'b000:  ext_c = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_c = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_c = {24'h0, byte_sel};
      3'b101:  ext_c = {16'h0, half_sel};
      default: ext_c = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q   <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      loadrd_q <= '0;
    end else begin
      err_q <= bad_align || timeout;
      if (start) begin
        addr_q  <= addr_i;
        f3_q    <= funct3_i;
        rd_q    <= rd_i;
        wdata_q <= wdata_i;
        we_q    <= memWr_i;
        wait_q  <= '0;
      end else if (state == ACCESS && !dmem_ready_i) begin
        wait_q <= wait_q + 8'd1;
      end
      // Result registers keep their last value; only loadValid_o qualifies them.
      if (state == ACCESS && dmem_ready_i && !we_q) begin
        result_q <= ext_c;
        loadrd_q <= rd_q;
      end
    end
  end

  assign err_o        = err_q;
  assign loadResult_o = result_q;
  assign loadrd_o     = loadrd_q;

endmodule
